// File: rtl/bcd_cnt_n_if.sv
// Control and data bundle for bcd_cnt_n. The master drives the controls and
// the load value; the slave returns the packed-BCD count and carry/borrow.
interface bcd_cnt_n_if #(
  parameter int W = 8
);
  logic         CLR;
  logic         EN;
  logic         INC;
  logic         LD;
  logic [W-1:0] DIN;
  logic         DN;
  logic [W-1:0] Q;
  logic         CA;

  modport master (
    output CLR, EN, INC, LD, DIN, DN,
    input  Q, CA
  );

  modport slave (
    input  CLR, EN, INC, LD, DIN, DN,
    output Q, CA
  );
endinterface

// File: rtl/bcd_cnt_n.sv
// N-digit packed-BCD counter, 0..LIMIT, with clear, sanitised load, level enable and
// edge-qualified manual increment. Define BCD_CNT_DOWN_EN to add DN-controlled down counting.
module bcd_cnt_n #(
  parameter int                  DIGITS = 2,
  parameter logic [4*DIGITS-1:0] LIMIT  = {DIGITS{4'h9}}
) (
  input logic        CLK,
  input logic        NRST,
  bcd_cnt_n_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] q;
  logic [W-1:0] q_inc;
  logic [W-1:0] q_step;
  logic [W-1:0] din_sat;
  logic [W-1:0] din_load;
  logic         inc_q;
  logic         step;
  logic         at_lim;
  logic         wrap;

  assign step   = bus.EN | (bus.INC & ~inc_q);
  assign at_lim = (q == LIMIT);

  // Ripple +1 across digits: a 9 rolls to 0 and passes the carry upward.
  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin : incrementer
    logic carry;
    q_inc = q;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (q[4*k +: 4] == 4'd9) begin
          q_inc[4*k +: 4] = 4'd0;
        end else begin
          q_inc[4*k +: 4] = q[4*k +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

`ifdef BCD_CNT_DOWN_EN
  logic [W-1:0] q_dec;
  logic         at_zero;

  assign at_zero = (q == '0);

  // Ripple -1 across digits: a 0 becomes 9 and borrows from the next digit.
  always_comb begin : decrementer
    logic borrow;
    q_dec  = q;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (q[4*k +: 4] == 4'd0) begin
          q_dec[4*k +: 4] = 4'd9;
        end else begin
          q_dec[4*k +: 4] = q[4*k +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  assign wrap   = bus.DN ? at_zero : at_lim;
  assign q_step = bus.DN ? (at_zero ? LIMIT : q_dec)
                         : (at_lim  ? '0    : q_inc);
`else
  logic unused_dn;
  assign unused_dn = bus.DN;
  assign wrap      = at_lim;
  assign q_step    = at_lim ? '0 : q_inc;
`endif

  // Clamp each non-BCD digit to 9; a valid packed-BCD word then compares
  // correctly as a plain unsigned number, so LIMIT needs no digit-wise compare.
  always_comb begin
    din_sat = '0;
    for (int k = 0; k < DIGITS; k++) begin
      din_sat[4*k +: 4] = (bus.DIN[4*k +: 4] > 4'd9) ? 4'd9 : bus.DIN[4*k +: 4];
    end
  end

  assign din_load = (din_sat > LIMIT) ? LIMIT : din_sat;

  assign bus.CA = step & ~bus.CLR & ~bus.LD & wrap;
  assign bus.Q  = q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      q     <= '0;
      inc_q <= 1'b0;
    end else begin
      inc_q <= bus.INC;
      if (bus.CLR) begin
        q <= '0;
      end else if (bus.LD) begin
        q <= din_load;
      end else if (step) begin
        q <= q_step;
      end
    end
  end
endmodule

// File: tb/tb_bcd_cnt_n.sv
// Self-checking bench for bcd_cnt_n: a mod-60 two-digit instance and a three-digit mod-1000
// instance, both checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_cnt_n;
`ifdef BCD_CNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic NRST;
  int   checks   = 0;
  int   failures = 0;

  // Reference state per instance, kept as plain decimal integers.
  int ndig [2] = '{2, 3};
  int lim  [2] = '{59, 999};
  int mq   [2];
  bit mincq[2];

  bcd_cnt_n_if #(.W(8))  ifa ();
  bcd_cnt_n_if #(.W(12)) ifb ();

  bcd_cnt_n #(.DIGITS(2), .LIMIT(8'h59))   dut_a (.CLK(CLK), .NRST(NRST), .bus(ifa));
  bcd_cnt_n #(.DIGITS(3), .LIMIT(12'h999)) dut_b (.CLK(CLK), .NRST(NRST), .bus(ifb));

  always #5 CLK = ~CLK;

  function automatic int bcd_sat2int(input logic [11:0] v, input int nd);
    int r = 0;
    int p = 1;
    for (int k = 0; k < nd; k++) begin
      int dg = int'(v[4*k +: 4]);
      if (dg > 9) dg = 9;
      r += dg * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] int2bcd(input int v, input int nd);
    logic [11:0] r = '0;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic set_idle();
    ifa.CLR = 0; ifa.LD = 0; ifa.EN = 0; ifa.INC = 0; ifa.DN = 0; ifa.DIN = '0;
    ifb.CLR = 0; ifb.LD = 0; ifb.EN = 0; ifb.INC = 0; ifb.DN = 0; ifb.DIN = '0;
  endtask

  // One clock cycle: drive instance sel (the other idles), compare CA against the
  // model before the edge and Q for both instances after it.
  task automatic cyc(input int sel, input bit clr, input bit ld, input bit en,
                     input bit inc, input bit dn, input logic [11:0] din, input string tag);
    bit c[2], l[2], e[2], i[2], n[2];
    logic [11:0] dv[2];
    for (int d = 0; d < 2; d++) begin
      c[d] = 0; l[d] = 0; e[d] = 0; i[d] = 0; n[d] = 0; dv[d] = '0;
    end
    c[sel] = clr; l[sel] = ld; e[sel] = en; i[sel] = inc; n[sel] = dn; dv[sel] = din;
    ifa.CLR = c[0]; ifa.LD = l[0]; ifa.EN = e[0]; ifa.INC = i[0]; ifa.DN = n[0]; ifa.DIN = dv[0][7:0];
    ifb.CLR = c[1]; ifb.LD = l[1]; ifb.EN = e[1]; ifb.INC = i[1]; ifb.DN = n[1]; ifb.DIN = dv[1];
    #1;
    for (int d = 0; d < 2; d++) begin
      bit step = e[d] | (i[d] & ~mincq[d]);
      bit down = DOWN_EN & n[d];
      bit wrp  = down ? (mq[d] == 0) : (mq[d] == lim[d]);
      bit exp_ca = step & ~c[d] & ~l[d] & wrp;
      logic act_ca = (d == 0) ? ifa.CA : ifb.CA;
      checks++;
      if (act_ca !== exp_ca) begin
        failures++;
        $display("FAIL %s ca dut%0d: got %b expected %b (model q=%0d)", tag, d, act_ca, exp_ca, mq[d]);
      end
      if (c[d])       mq[d] = 0;
      else if (l[d])  begin
        int s = bcd_sat2int(dv[d], ndig[d]);
        mq[d] = (s > lim[d]) ? lim[d] : s;
      end
      else if (step)  mq[d] = down ? ((mq[d] == 0) ? lim[d] : mq[d] - 1)
                                   : ((mq[d] == lim[d]) ? 0 : mq[d] + 1);
      mincq[d] = i[d];
    end
    @(posedge CLK); #1;
    for (int d = 0; d < 2; d++) begin
      logic [11:0] act_q = (d == 0) ? {4'h0, ifa.Q} : ifb.Q;
      logic [11:0] exp_q = int2bcd(mq[d], ndig[d]);
      checks++;
      if (act_q !== exp_q) begin
        failures++;
        $display("FAIL %s q dut%0d: got %h expected %h", tag, d, act_q, exp_q);
      end
    end
  endtask

  task automatic test_reset();
    set_idle();
    NRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (ifa.Q !== 8'h00 || ifb.Q !== 12'h000 || ifa.CA !== 1'b0 || ifb.CA !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: got qa=%h qb=%h ca=%b%b expected 00 000 00", ifa.Q, ifb.Q, ifa.CA, ifb.CA);
    end
    #2 NRST = 1'b1;
    for (int d = 0; d < 2; d++) begin mq[d] = 0; mincq[d] = 0; end
    cyc(0, 0, 1, 0, 0, 0, 12'h037, "reset_load37");
    set_idle();
    #2 NRST = 1'b0;
    #1;
    checks++;
    if (ifa.Q !== 8'h00 || ifa.CA !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got q=%h ca=%b expected 00 0", ifa.Q, ifa.CA);
    end
    for (int d = 0; d < 2; d++) begin mq[d] = 0; mincq[d] = 0; end
    #1 NRST = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, '0, "reset_inc_release");
    checks++;
    if (ifa.Q !== 8'h01) begin
      failures++;
      $display("FAIL reset_inc_once: got %h expected 01", ifa.Q);
    end
    cyc(0, 0, 0, 0, 1, 0, '0, "reset_inc_hold");
  endtask

  task automatic test_mod60();
    int ca_high = 0;
    cyc(0, 1, 0, 0, 0, 0, '0, "mod60_clr");
    for (int n = 0; n < 60; n++) begin
      ifa.EN = 1'b1;
      #1;
      if (ifa.CA === 1'b1) ca_high++;
      cyc(0, 0, 0, 1, 0, 0, '0, "mod60_run");
    end
    checks++;
    if (ifa.Q !== 8'h00 || ca_high != 1) begin
      failures++;
      $display("FAIL mod60_wrap: got q=%h ca_cycles=%0d expected 00 1", ifa.Q, ca_high);
    end
  endtask

  task automatic test_inc_edge();
    int start;
    cyc(0, 0, 1, 0, 0, 0, 12'h020, "inc_load");
    start = 20;
    for (int n = 0; n < 5; n++) cyc(0, 0, 0, 0, 1, 0, '0, "inc_hi5");
    for (int n = 0; n < 2; n++) cyc(0, 0, 0, 0, 0, 0, '0, "inc_lo2");
    cyc(0, 0, 0, 0, 1, 0, '0, "inc_hi1");
    checks++;
    if (ifa.Q !== int2bcd(start + 2, 2)) begin
      failures++;
      $display("FAIL inc_edge_plus2: got %h expected %h", ifa.Q, int2bcd(start + 2, 2));
    end
    cyc(0, 0, 0, 0, 0, 0, '0, "inc_gap");
    cyc(0, 0, 0, 1, 1, 0, '0, "inc_with_en");
    checks++;
    if (ifa.Q !== int2bcd(start + 3, 2)) begin
      failures++;
      $display("FAIL inc_en_plus1: got %h expected %h", ifa.Q, int2bcd(start + 3, 2));
    end
  endtask

  task automatic test_load();
    cyc(0, 0, 1, 0, 0, 0, 12'h07A, "load_7A");
    checks++;
    if (ifa.Q !== 8'h59) begin
      failures++;
      $display("FAIL load_7A: got %h expected 59", ifa.Q);
    end
    cyc(0, 0, 1, 0, 0, 0, 12'h03F, "load_3F");
    checks++;
    if (ifa.Q !== 8'h39) begin
      failures++;
      $display("FAIL load_3F: got %h expected 39", ifa.Q);
    end
    cyc(0, 0, 1, 0, 0, 0, 12'h059, "load_59");
    ifa.LD = 1'b1; ifa.EN = 1'b1; ifa.DIN = 8'h21;
    #1;
    checks++;
    if (ifa.CA !== 1'b0) begin
      failures++;
      $display("FAIL load_en_ca: got %b expected 0", ifa.CA);
    end
    cyc(0, 0, 1, 1, 0, 0, 12'h021, "load_en");
    checks++;
    if (ifa.Q !== 8'h21) begin
      failures++;
      $display("FAIL load_wins: got %h expected 21", ifa.Q);
    end
  endtask

  task automatic test_priority();
    cyc(0, 0, 1, 0, 0, 0, 12'h059, "prio_pre");
    cyc(0, 1, 1, 1, 0, 0, 12'h012, "prio_clr_ld_en");
    checks++;
    if (ifa.Q !== 8'h00) begin
      failures++;
      $display("FAIL prio_clear: got %h expected 00", ifa.Q);
    end
  endtask

  task automatic test_down();
    cyc(1, 0, 1, 0, 0, 0, 12'h100, "down_load100");
    cyc(1, 0, 0, 1, 0, 1, '0, "down_100");
    checks++;
    if (ifb.Q !== (DOWN_EN ? 12'h099 : 12'h101)) begin
      failures++;
      $display("FAIL down_100: got %h expected %h", ifb.Q, DOWN_EN ? 12'h099 : 12'h101);
    end
    cyc(1, 1, 0, 0, 0, 0, '0, "down_clr");
    cyc(1, 0, 0, 1, 0, 1, '0, "down_000");
    checks++;
    if (ifb.Q !== (DOWN_EN ? 12'h999 : 12'h001)) begin
      failures++;
      $display("FAIL down_000: got %h expected %h", ifb.Q, DOWN_EN ? 12'h999 : 12'h001);
    end
    cyc(1, 0, 1, 0, 0, 0, 12'h999, "up_load999");
    cyc(1, 0, 0, 1, 0, 0, '0, "up_999");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int sel = int'($urandom_range(0, 1));
      bit clr = ($urandom_range(0, 15) == 0);
      bit ld  = ($urandom_range(0, 7) == 0);
      bit en  = $urandom_range(0, 1) == 1;
      bit inc = $urandom_range(0, 1) == 1;
      bit dn  = $urandom_range(0, 1) == 1;
      logic [11:0] din = 12'($urandom);
      cyc(sel, clr, ld, en, inc, dn, din, "random");
    end
  endtask

  initial begin
    test_reset();
    test_mod60();
    test_inc_edge();
    test_load();
    test_priority();
    test_down();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
